branch_sequencer: RTL
=====================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_W, default 8, meaning the bit width of the bracket nesting-depth counter.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port instruction, input, op_code: the currently fetched instruction.
REQ-005 SHALL have port instr_valid, input, 1 bit: instruction is valid this cycle; when low, all state holds.
REQ-006 SHALL have port acc_zero, input, 1 bit: the current data cell equals zero.
REQ-007 SHALL have port branch_mode, output, 1 bit: high selects the branch_control bundle; low selects normal decode.
REQ-008 SHALL have port pc_step, output, 1 bit: advance the PC this cycle.
REQ-009 SHALL have port pc_dir, output, 1 bit: PC direction, 0 = forward (+1), 1 = backward (-1).
REQ-010 SHALL have port depth, output, DEPTH_W bits: the current nesting depth.
REQ-011 SHALL have port depth_err, output, 1 bit: sticky nesting-overflow flag.

Function
REQ-012 SHALL implement the states IDLE, SCAN_FWD, SCAN_BWD and HALT, held in a registered state register.
REQ-013 SHALL, in IDLE with instr_valid=1 and instruction=CBF and acc_zero=1, go to SCAN_FWD with depth=1, pc_step=1, pc_dir=0.
REQ-014 SHALL, in IDLE with instr_valid=1 and instruction=CBB and acc_zero=0, go to SCAN_BWD with depth=1, pc_step=1, pc_dir=1.
REQ-015 SHALL, in IDLE for any other valid instruction (including CBF with acc_zero=0 and CBB with acc_zero=1), stay in IDLE with pc_step=1, pc_dir=0.
REQ-016 SHALL, in SCAN_FWD, change depth as follows: CBF adds 1, CBB subtracts 1, other opcodes leave it unchanged; pc_dir=0.
REQ-017 SHALL, in SCAN_BWD, change depth as follows: CBB adds 1, CBF subtracts 1, other opcodes leave it unchanged; pc_dir=1.
REQ-018 SHALL, when a scan-state decrement takes depth from 1 to 0 (the matching bracket), return to IDLE with pc_step=1 and pc_dir=0, leaving the PC one past the matching bracket.
REQ-019 SHALL drive branch_mode=1 exactly when the state is SCAN_FWD or SCAN_BWD, including the match cycle.
REQ-020 SHALL derive pc_step, pc_dir and branch_mode combinationally from the state, instruction and acc_zero, giving zero-cycle latency; depth and state SHALL update at the clock edge.
REQ-021 SHALL, whenever instr_valid=0, drive pc_step=0 and hold state and depth unchanged.
REQ-022 SHALL, in HALT, drive pc_step=0 and branch_mode=0 until reset.
REQ-023 SHALL ignore acc_zero while in a scan state.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set state=IDLE, depth=0 and depth_err=0, overriding all other activity including reset mid-scan.
REQ-025 SHALL, while reset=1, drive branch_mode=0 and pc_step=0.

Configuration
REQ-026 SHALL, with BRANCH_DEPTH_CHECK_EN defined, treat an increment at depth=2^DEPTH_W-1 as overflow: depth holds, depth_err is set, and the state goes to HALT.
REQ-027 SHALL, without BRANCH_DEPTH_CHECK_EN, let depth wrap modulo 2^DEPTH_W, tie depth_err to 0, and make HALT unreachable.

Verification
REQ-028 SHALL cover: acc_zero=1 with stream CBF,NOP,CBF,CBB,CBB -> depths 1,1,2,1,0; branch_mode 0,1,1,1,1 then 0; final state IDLE, pc_dir=0.
REQ-029 SHALL cover: acc_zero=0 with stream CBB,NOP,CBB,CBF,CBF -> pc_dir=1 for 4 cycles; depth 1,1,2,1,0; last cycle pc_dir=0; state IDLE.
REQ-030 SHALL cover: CBF with acc_zero=0 and CBB with acc_zero=1 -> no scan; branch_mode stays 0; pc_step=1, pc_dir=0.
REQ-031 SHALL cover: instr_valid=0 for 3 cycles mid-scan at depth=2 -> pc_step=0; depth stays 2; the scan resumes correctly.
REQ-032 SHALL cover: reset asserted during SCAN_FWD at depth=3 -> the next cycle shows state IDLE, depth=0, branch_mode=0.
REQ-033 SHALL cover: DEPTH_W=2 with macro defined and 4 nested CBF in SCAN_FWD -> depth_err=1, HALT, pc_step=0; without the macro -> depth wraps 3 to 0, depth_err=0.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: opcode package and bus bundle between fetch/decode and the bracket-matching sequencer
package branch_sequencer_pkg;
  typedef enum logic [2:0] {
    OP_NOP,
    OP_INC,
    OP_DEC,
    OP_RIGHT,
    OP_LEFT,
    OP_OUT,
    OP_CBF,
    OP_CBB
  } op_code;
endpackage

interface branch_sequencer_if
  import branch_sequencer_pkg::*;
#(
  parameter int DEPTH_W = 8
);
  op_code             instruction;
  logic               instr_valid;
  logic               acc_zero;
  logic               branch_mode;
  logic               pc_step;
  logic               pc_dir;
  logic [DEPTH_W-1:0] depth;
  logic               depth_err;
  modport master (
    output instruction, instr_valid, acc_zero,
    input  branch_mode, pc_step, pc_dir, depth, depth_err
  );
  modport slave (
    input  instruction, instr_valid, acc_zero,
    output branch_mode, pc_step, pc_dir, depth, depth_err
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: scans for the matching CBF/CBB bracket; optional overflow trap via BRANCH_DEPTH_CHECK_EN
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input logic              clock,
  input logic              reset,
  branch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN_FWD, SCAN_BWD, HALT} state_t;
  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               depth_err_q, depth_err_d;
  logic               scan, fwd, inc, dec, match, ovf, enter_fwd, enter_bwd;
  // state, depth and sticky error registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      depth_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      depth_err_q <= depth_err_d;
    end
  end
  // next-state, depth update and zero-latency PC control
  always_comb begin
    scan      = state_q == SCAN_FWD || state_q == SCAN_BWD;
    fwd       = state_q == SCAN_FWD;
    inc       = scan && bus.instruction == (fwd ? OP_CBF : OP_CBB);
    dec       = scan && bus.instruction == (fwd ? OP_CBB : OP_CBF);
    match     = dec && depth_q == DEPTH_W'(1);
`ifdef BRANCH_DEPTH_CHECK_EN
    ovf       = inc && &depth_q;
`else
    ovf       = 1'b0;
`endif
    enter_fwd = state_q == IDLE && bus.instruction == OP_CBF && bus.acc_zero;
    enter_bwd = state_q == IDLE && bus.instruction == OP_CBB && !bus.acc_zero;
    state_d   = !bus.instr_valid ? state_q :
                enter_fwd        ? SCAN_FWD :
                enter_bwd        ? SCAN_BWD :
                match            ? IDLE :
                ovf              ? HALT : state_q;
    depth_d   = (!bus.instr_valid || ovf) ? depth_q :
                (enter_fwd || enter_bwd) ? DEPTH_W'(1) :
                inc                      ? depth_q + 1'b1 :
                dec                      ? depth_q - 1'b1 : depth_q;
    depth_err_d = depth_err_q || (bus.instr_valid && ovf);
    bus.branch_mode = !reset && scan;
    bus.pc_step     = !reset && bus.instr_valid && state_q != HALT && !ovf;
    bus.pc_dir      = !match && (enter_bwd || state_q == SCAN_BWD);
    bus.depth       = depth_q;
    bus.depth_err   = depth_err_q;
  end
endmodule
